// File: rtl/gpr_bypass_sb_pkg.sv
// Shared datapath constants for the pipelined register file.
package gpr_bypass_sb_pkg;

  localparam int unsigned GPR_DATA_W    = 32;
  localparam int unsigned GPR_ADDR_W    = 5;
  localparam int unsigned GPR_OVF_CNT_W = 8;
  localparam int unsigned REG_ZERO      = 0;

endpackage : gpr_bypass_sb_pkg

// File: rtl/gpr_bypass_sb_ovf_counter.sv
// Sticky overflow flag with a saturating event counter; clear beats increment.
module ovf_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic             flag,
  output logic [CNT_W-1:0] cnt
);

  logic             r_flag;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag <= 1'b0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_flag <= 1'b0;
      r_cnt  <= '0;
    end else if (inc) begin
      r_flag <= 1'b1;
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign flag = r_flag;
  assign cnt  = r_cnt;

endmodule : ovf_counter

// File: rtl/gpr_bypass_sb.sv
// General-purpose register file with write-to-read bypass, pending-write
// scoreboard and overflow tracking.
module gpr_bypass_sb
  import gpr_bypass_sb_pkg::*;
#(
  parameter int unsigned DATA_W    = GPR_DATA_W,
  parameter int unsigned ADDR_W    = GPR_ADDR_W,
  parameter int unsigned OVF_CNT_W = GPR_OVF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    ra,
  input  logic [ADDR_W-1:0]    rb,
  output logic [DATA_W-1:0]    rda,
  output logic [DATA_W-1:0]    rdb,
  output logic                 busy_a,
  output logic                 busy_b,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_rd,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    rw,
  input  logic [DATA_W-1:0]    wd,
  input  logic                 overflow,
  input  logic                 ovf_clr,
  output logic                 ovf_flag,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic w_retire;
  logic w_commit;
  logic w_issue;
  logic w_byp_a;
  logic w_byp_b;
  logic w_clr_a;
  logic w_clr_b;

  // A retire frees the scoreboard entry even if the result is discarded.
  assign w_retire = we && (rw != ADDR_ZERO);
  assign w_commit = w_retire && !overflow;
  assign w_issue  = iss_en && (iss_rd != ADDR_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[rw] <= wd;
    end
  end

  // Issue is applied after retire so a same-register collision stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (w_retire) begin
        r_pend[rw] <= 1'b0;
      end
      if (w_issue) begin
        r_pend[iss_rd] <= 1'b1;
      end
    end
  end

  assign w_byp_a = w_commit && (rw == ra);
  assign w_byp_b = w_commit && (rw == rb);
  assign w_clr_a = w_retire && (rw == ra);
  assign w_clr_b = w_retire && (rw == rb);

  // Gate with rst so an in-flight commit cannot leak through the bypass.
  always_comb begin
    rda = '0;
    rdb = '0;
    if (!rst && (ra != ADDR_ZERO)) begin
      rda = w_byp_a ? wd : r_regs[ra];
    end
    if (!rst && (rb != ADDR_ZERO)) begin
      rdb = w_byp_b ? wd : r_regs[rb];
    end
  end

  assign busy_a = !rst && r_pend[ra] && !w_clr_a;
  assign busy_b = !rst && r_pend[rb] && !w_clr_b;

  ovf_counter #(
    .CNT_W (OVF_CNT_W)
  ) u_ovf_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (we && overflow),
    .clr  (ovf_clr),
    .flag (ovf_flag),
    .cnt  (ovf_cnt)
  );

endmodule : gpr_bypass_sb

// File: tb/tb_gpr_bypass_sb.sv
// Directed bench for gpr_bypass_sb with hand-computed expectations.
module tb_gpr_bypass_sb;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned OVF_CNT_W = 2;

  logic                 clk;
  logic                 rst;
  logic [ADDR_W-1:0]    ra;
  logic [ADDR_W-1:0]    rb;
  logic [DATA_W-1:0]    rda;
  logic [DATA_W-1:0]    rdb;
  logic                 busy_a;
  logic                 busy_b;
  logic                 iss_en;
  logic [ADDR_W-1:0]    iss_rd;
  logic                 we;
  logic [ADDR_W-1:0]    rw;
  logic [DATA_W-1:0]    wd;
  logic                 overflow;
  logic                 ovf_clr;
  logic                 ovf_flag;
  logic [OVF_CNT_W-1:0] ovf_cnt;

  int n_checks = 0;
  int n_errors = 0;

  gpr_bypass_sb #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .OVF_CNT_W (OVF_CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ra       (ra),
    .rb       (rb),
    .rda      (rda),
    .rdb      (rdb),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .we       (we),
    .rw       (rw),
    .wd       (wd),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .ovf_flag (ovf_flag),
    .ovf_cnt  (ovf_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_en = 1'b0; we = 1'b0; overflow = 1'b0; ovf_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ra = '0; rb = '0; iss_rd = '0; rw = '0; wd = '0;
    idle();
    step(); step();
    check("rst_rda", rda, 32'h0);
    check("rst_busy_a", 32'(busy_a), 32'h0);
    check("rst_flag", 32'(ovf_flag), 32'h0);
    check("rst_cnt", 32'(ovf_cnt), 32'h0);
    rst = 1'b0;
    step();

    // Populate reg 3, mark it pending, log an overflow to rw=0.
    we = 1'b1; rw = 5'd3; wd = 32'h1234; ra = 5'd3;
    #1 check("w3_bypass", rda, 32'h1234);
    step();
    we = 1'b0; iss_en = 1'b1; iss_rd = 5'd3;
    #1 check("w3_stored", rda, 32'h1234);
    step();
    idle(); we = 1'b1; overflow = 1'b1; rw = 5'd0; wd = 32'hFFFF;
    step();
    idle();
    #1 check("pre_rst_busy", 32'(busy_a), 32'h1);
    check("ovf_rw0_flag", 32'(ovf_flag), 32'h1);
    check("ovf_rw0_cnt", 32'(ovf_cnt), 32'h1);

    // Mid-run asynchronous reset with an in-flight write to reg 3.
    #2 rst = 1'b1; we = 1'b1; rw = 5'd3; wd = 32'h5555;
    #1 check("mid_rst_rda", rda, 32'h0);
    check("mid_rst_busy", 32'(busy_a), 32'h0);
    check("mid_rst_flag", 32'(ovf_flag), 32'h0);
    check("mid_rst_cnt", 32'(ovf_cnt), 32'h0);
    step();
    idle(); rst = 1'b0;
    step();
    check("post_rst_rda", rda, 32'h0);

    // Write and bypass, reg 0 stays zero.
    we = 1'b1; rw = 5'd5; wd = 32'hDEADBEEF; ra = 5'd5;
    #1 check("w5_bypass", rda, 32'hDEADBEEF);
    step();
    idle();
    #1 check("w5_stored", rda, 32'hDEADBEEF);
    we = 1'b1; rw = 5'd0; wd = 32'hFFFFFFFF; ra = 5'd0;
    #1 check("w0_bypass", rda, 32'h0);
    step();
    idle();
    #1 check("w0_stored", rda, 32'h0);

    // Scoreboard: issue, retire, and collision on reg 7.
    iss_en = 1'b1; iss_rd = 5'd7; ra = 5'd7;
    #1 check("iss7_same_cycle", 32'(busy_a), 32'h0);
    step();
    idle();
    #1 check("iss7_next", 32'(busy_a), 32'h1);
    we = 1'b1; rw = 5'd7; wd = 32'h77;
    #1 check("wb7_clear_now", 32'(busy_a), 32'h0);
    step();
    idle();
    #1 check("wb7_after", 32'(busy_a), 32'h0);
    iss_en = 1'b1; iss_rd = 5'd7; we = 1'b1; rw = 5'd7; wd = 32'h78;
    #1 check("coll7_now", 32'(busy_a), 32'h0);
    step();
    idle();
    #1 check("coll7_after", 32'(busy_a), 32'h1);
    check("coll7_data", rda, 32'h78);

    // Overflowed writeback to reg 4: data kept, pend cleared, counted.
    we = 1'b1; rw = 5'd4; wd = 32'h11; iss_en = 1'b1; iss_rd = 5'd4; ra = 5'd4;
    step();
    idle();
    #1 check("ovf4_busy_before", 32'(busy_a), 32'h1);
    we = 1'b1; overflow = 1'b1; rw = 5'd4; wd = 32'h55;
    #1 check("ovf4_no_bypass", rda, 32'h11);
    check("ovf4_busy_now", 32'(busy_a), 32'h0);
    step();
    idle();
    #1 check("ovf4_reg", rda, 32'h11);
    check("ovf4_busy_after", 32'(busy_a), 32'h0);
    check("ovf4_flag", 32'(ovf_flag), 32'h1);
    check("ovf4_cnt", 32'(ovf_cnt), 32'h1);

    // Four more overflows (five total) saturate a 2-bit counter at 3.
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; overflow = 1'b1; rw = 5'd4; wd = 32'h66;
      step();
      idle();
      if (i == 1) check("ovf_cnt_3", 32'(ovf_cnt), 32'h3);
    end
    check("ovf_sat", 32'(ovf_cnt), 32'h3);
    check("ovf_sat_flag", 32'(ovf_flag), 32'h1);
    we = 1'b1; overflow = 1'b1; ovf_clr = 1'b1; rw = 5'd4;
    step();
    idle();
    #1 check("clr_flag", 32'(ovf_flag), 32'h0);
    check("clr_cnt", 32'(ovf_cnt), 32'h0);

    // Dual-port independence.
    we = 1'b1; rw = 5'd10; wd = 32'hA0A0; iss_en = 1'b1; iss_rd = 5'd10;
    step();
    idle();
    we = 1'b1; rw = 5'd9; wd = 32'h99; ra = 5'd9; rb = 5'd9;
    #1 check("dual_a", rda, 32'h99);
    check("dual_b", rdb, 32'h99);
    rb = 5'd10;
    #1 check("split_a", rda, 32'h99);
    check("split_b", rdb, 32'hA0A0);
    check("split_busy_b", 32'(busy_b), 32'h1);
    step();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_gpr_bypass_sb

// File: doc/gpr_bypass_sb.md
# gpr_bypass_sb

Parametrised general-purpose register file for the pipelined datapath. It succeeds the single-cycle register file and adds:
- configurable data width and register count;
- write-to-read bypass;
- a per-register pending scoreboard for hazard detection;
- a sticky, clearable overflow flag with a saturating overflow counter.

It sits between the decode stage (reads, issue) and the writeback stage (writes).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- OVF_CNT_W, 8, width of the saturating overflow counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ra  in  ADDR_W  read address, port A
- rb  in  ADDR_W  read address, port B
- rda  out  DATA_W  read data, port A
- rdb  out  DATA_W  read data, port B
- busy_a  out  1  register ra has a pending write
- busy_b  out  1  register rb has a pending write
- iss_en  in  1  decode issues an instruction that will write register iss_rd
- iss_rd  in  ADDR_W  destination register of the issued instruction
- we  in  1  writeback write enable
- rw  in  ADDR_W  writeback address
- wd  in  DATA_W  writeback data
- overflow  in  1  the writeback result overflowed; suppresses the write
- ovf_clr  in  1  clear the sticky overflow flag and the counter
- ovf_flag  out  1  sticky overflow flag
- ovf_cnt  out  OVF_CNT_W  saturating count of overflowed writebacks

## Operation
**Register 0**
- Reads as 0.
- Never written.
- Never marked pending.

**Commit rule**
- A write commits at posedge clk when `we && rw!=0 && !overflow`, giving reg[rw] <= wd.

**Reads and bypass**
- Reads are combinational.
- If a commit to the read address is active in the same cycle, the port returns wd instead of the stored value. This gives write-before-read semantics for each of rda and rdb independently.

**Scoreboard**
- pend[iss_rd] is set on `iss_en && iss_rd!=0`.
- pend[rw] is cleared on any `we` with rw!=0, including an overflowed writeback, because the instruction has retired.
- Simultaneous set and clear on the same register: the set wins and pend stays 1 (a new producer was issued).
- busy_a = pend[ra] && !(clear of ra this cycle). busy_b is defined the same way for rb.
- busy_a and busy_b are 0 for address 0.

**Overflow**
- Any `we && overflow` sets ovf_flag.
- The same event increments ovf_cnt, saturating at all-ones.
- ovf_clr has priority over a simultaneous overflow: both ovf_flag and ovf_cnt end the cycle at 0.
- Overflow with rw==0 still counts.

**Reset**
- All registers 0, all pend 0, ovf_flag 0, ovf_cnt 0.
- Consequently rda, rdb, busy_a and busy_b are 0 while rst is high.
- Reset asserted mid-operation discards pending state immediately and drops any in-flight commit.

## Timing
- Read latency: 0 cycles (combinational from ra/rb and the bypass inputs).
- Write latency: 1 edge. The stored value is visible on the next cycle without bypass and in the same cycle with bypass.
- pend, ovf_flag and ovf_cnt update on posedge clk.
- busy_* reflects a writeback clear in the same cycle. It reflects an issue only from the next cycle.
- No handshake stalls. The block accepts an issue and a writeback every cycle.

## Structure
**Shared datapath package**
- Constants: DATA_W=32, ADDR_W=5, REG_ZERO=0.

**Sub-module ovf_counter**
- Contains the sticky flag and the saturating counter.
- Inputs: clk, rst, inc, clr.

**Top level**
- Register array.
- Bypass muxes.
- Pending bit vector.

## Test plan
- **Reset:** assert rst mid-run after writing reg 3 = 0x1234 -> rda(ra=3)=0, ovf_flag=0, ovf_cnt=0, busy_a=0.
- **Write and bypass:** we=1, rw=5, wd=0xDEADBEEF, ra=5 in the same cycle -> rda=0xDEADBEEF that cycle and after the edge. Writing rw=0 -> rda(ra=0) stays 0.
- **Scoreboard:** issue iss_rd=7 -> busy_a(ra=7)=1 next cycle. Writeback rw=7 -> busy_a=0 in that cycle. Issue and writeback to 7 in the same cycle -> busy_a=1 afterwards.
- **Overflow:** we=1, overflow=1, rw=4, wd=0x55 -> reg 4 unchanged, pend[4] cleared, ovf_flag=1, ovf_cnt=1.
- **Counter saturation and clear:** with OVF_CNT_W=2, 5 overflowed writebacks -> ovf_cnt=3. ovf_clr together with an overflow -> ovf_flag=0, ovf_cnt=0.
- **Dual-port independence:** ra=rb=9 while writing 9 -> both ports are bypassed. ra=9, rb=10 -> only rda is bypassed, and rdb returns stored reg 10.
